// File: rtl/pmem_arbiter.sv
`timescale 1ns/1ps
// pmem_arbiter
// Shares one physical-memory port between the I-cache miss path and the
// D-cache miss path. One line-sized transaction is granted at a time, and the
// memory response is routed back to the side that owns the grant. Conflicts
// are resolved round-robin. On the first tie after reset, D wins.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_read, i_address    I-side line read request and its address
//   i_rdata, i_resp      I-side line data (qualified by i_resp) and done pulse
//   d_read, d_write      D-side line read / writeback request
//   d_address, d_wdata   D-side address and writeback data
//   d_rdata, d_resp      D-side line data (qualified by d_resp) and done pulse
//   pmem_*               memory port: read/write strobes, address, write data,
//                        read data and done pulse
//   cnt_*                saturating counters: I grants, D grants, and IDLE
//                        cycles in which both sides request
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  cnt_i_grants,
  output logic [CNT_W-1:0]  cnt_d_grants,
  output logic [CNT_W-1:0]  cnt_conflicts
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_d;
  logic   i_req, d_req;
  logic   grant_i, grant_d, conflict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign i_req    = i_read;
  assign d_req    = d_read | d_write;
  assign conflict = (state == IDLE) && i_req && d_req;
  assign grant_i  = (state == IDLE) && (state_nxt == SERVE_I);
  assign grant_d  = (state == IDLE) && (state_nxt == SERVE_D);

  // Read data is a plain pass-through; only the resp pulse qualifies it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A SERVE state always falls back to IDLE, so every pair
  // of transactions is separated by at least one IDLE cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = last_d ? SERVE_I : SERVE_D;
        else if (i_req)     state_nxt = SERVE_I;
        else if (d_req)     state_nxt = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        // The grant is held even if the request is dropped, until memory answers.
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. Strobes depend on the registered state only; a new request
  // never reaches the memory port in the same cycle.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      SERVE_D: begin
        // An illegal read+write from D is forwarded unchanged.
        pmem_read    = d_read;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  // Round-robin history: remembers which side was granted most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_d <= 1'b0;
    else if (grant_i) last_d <= 1'b0;
    else if (grant_d) last_d <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_i_grants  <= '0;
      cnt_d_grants  <= '0;
      cnt_conflicts <= '0;
    end else begin
      if (grant_i)  cnt_i_grants  <= sat_inc(cnt_i_grants);
      if (grant_d)  cnt_d_grants  <= sat_inc(cnt_d_grants);
      if (conflict) cnt_conflicts <= sat_inc(cnt_conflicts);
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
`timescale 1ns/1ps
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic              side_d;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read, d_read, d_write, pmem_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [CNT_W-1:0]  cnt_i_grants, cnt_d_grants, cnt_conflicts;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  logic [CNT_W-1:0] m_i, m_d, m_c;
  logic             m_last_d;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .cnt_i_grants(cnt_i_grants), .cnt_d_grants(cnt_d_grants), .cnt_conflicts(cnt_conflicts)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  task automatic check_counters(input string tag);
    chkc({tag, "_cnt_i"}, cnt_i_grants, m_i);
    chkc({tag, "_cnt_d"}, cnt_d_grants, m_d);
    chkc({tag, "_cnt_c"}, cnt_conflicts, m_c);
  endtask

  // Record an expected grant in arbitration order and update the reference model.
  task automatic push(input logic side_d, input logic [ADDR_W-1:0] addr, input logic wr,
                      input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata);
    exp_t e;
    e.side_d = side_d; e.addr = addr; e.wr = wr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
    m_last_d = side_d;
    if (side_d) m_d = sat(m_d);
    else        m_i = sat(m_i);
  endtask

  // Memory-side responder: waits for a strobe, checks it against the oldest
  // expected grant, answers after 'lat' extra cycles, checks response routing.
  task automatic serve(input int lat, input logic drop, output int idle_n);
    exp_t e;
    int   n;
    logic got;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (pmem_read || pmem_write) got = 1'b1;
      else n++;
    end
    idle_n = n;
    chk1("grant_seen", got, 1'b1);
    if (!got) return;
    chk1("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      chk1("pmem_read", pmem_read, !e.wr);
      chk1("pmem_write", pmem_write, e.wr);
      chka("pmem_address", pmem_address, e.addr);
      if (e.wr) chkw("pmem_wdata", pmem_wdata, e.wdata);
      chk1("i_resp_wait", i_resp, 1'b0);
      chk1("d_resp_wait", d_resp, 1'b0);
    end
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = e.rdata;
    @(negedge clk);
    chk1("i_resp", i_resp, !e.side_d);
    chk1("d_resp", d_resp, e.side_d);
    chkw(e.side_d ? "d_rdata" : "i_rdata", e.side_d ? d_rdata : i_rdata, e.rdata);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    if (drop) begin
      if (e.side_d) begin d_read = 1'b0; d_write = 1'b0; end
      else i_read = 1'b0;
    end
  endtask

  task automatic tie_run(input string tag, input logic [ADDR_W-1:0] ai, input logic [ADDR_W-1:0] ad,
                         input logic [LINE_W-1:0] ri, input logic [LINE_W-1:0] rd);
    int   idle_n;
    logic first_d;
    @(posedge clk); #1;
    i_read = 1'b1; i_address = ai;
    d_read = 1'b1; d_address = ad;
    m_c = sat(m_c);
    first_d = !m_last_d;
    push(first_d, first_d ? ad : ai, 1'b0, '0, first_d ? rd : ri);
    push(!first_d, first_d ? ai : ad, 1'b0, '0, first_d ? ri : rd);
    serve(2, 1'b1, idle_n);
    chk1({tag, "_first_idle"}, idle_n == 1, 1'b1);
    serve(1, 1'b1, idle_n);
    chk1({tag, "_second_idle"}, idle_n == 1, 1'b1);
    check_counters(tag);
  endtask

  initial begin
    int idle_n;
    logic [LINE_W-1:0] pat;
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    m_i = '0; m_d = '0; m_c = '0; m_last_d = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk1("por_read", pmem_read, 1'b0);
    chk1("por_write", pmem_write, 1'b0);
    chk1("por_i_resp", i_resp, 1'b0);
    chk1("por_d_resp", d_resp, 1'b0);
    chka("por_addr", pmem_address, '0);
    chkw("por_wdata", pmem_wdata, '0);
    check_counters("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted in the middle of a D writeback
    d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    chk1("rst_no_strobe_c0", pmem_write, 1'b0);
    @(negedge clk);
    chk1("rst_write_c1", pmem_write, 1'b1);
    chkc("rst_dcnt_pre", cnt_d_grants, CNT_W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_write_drop", pmem_write, 1'b0);
    chk1("rst_read_drop", pmem_read, 1'b0);
    chka("rst_addr", pmem_address, '0);
    chkw("rst_wdata", pmem_wdata, '0);
    check_counters("rst");
    @(posedge clk); #1;
    d_write = 1'b0; pmem_resp = 1'b1; pmem_rdata = {32{8'h3C}};
    @(negedge clk);
    chk1("rst_late_d_resp", d_resp, 1'b0);
    chk1("rst_late_i_resp", i_resp, 1'b0);
    @(posedge clk); #1;
    pmem_resp = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_idle_read", pmem_read, 1'b0);
    chk1("rst_idle_write", pmem_write, 1'b0);

    // Tie right after reset: D first, then I
    tie_run("tie", 32'h0000_0100, 32'h0000_0200, {32{8'h11}}, {32{8'h22}});

    // Lone I read, strobe one cycle after the request, response four cycles in
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h0000_0040;
    push(1'b0, 32'h0000_0040, 1'b0, '0, {32{8'hA5}});
    serve(2, 1'b1, idle_n);
    chk1("lone_i_latency", idle_n == 1, 1'b1);
    check_counters("lone_i");

    // Continuous requests from both sides: grants alternate D,I,D,I,D,I
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h0000_0400;
    d_read = 1'b1; d_address = 32'h0000_0800;
    for (int k = 0; k < 6; k++) begin
      logic sd;
      if (k < 5) m_c = sat(m_c);
      sd = (k < 5) ? !m_last_d : 1'b0;
      push(sd, sd ? 32'h0000_0800 : 32'h0000_0400, 1'b0, '0, {8{k[7:0], 24'h5A5A5A}});
    end
    for (int k = 0; k < 6; k++) begin
      serve(1, k >= 4, idle_n);
      chk1("rr_one_idle", idle_n == 1, 1'b1);
    end
    check_counters("rr");

    // D writeback
    @(posedge clk); #1;
    pat = {16{16'h5A3C}};
    d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = pat;
    push(1'b1, 32'h0000_1000, 1'b1, pat, {32{8'h77}});
    serve(2, 1'b1, idle_n);
    check_counters("wb");

    // Spurious memory response while idle
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = {4{64'h0123_4567_89AB_CDEF}};
    @(negedge clk);
    chk1("spur_i_resp", i_resp, 1'b0);
    chk1("spur_d_resp", d_resp, 1'b0);
    chkw("spur_i_rdata_pass", i_rdata, {4{64'h0123_4567_89AB_CDEF}});
    @(posedge clk); #1 pmem_resp = 1'b0;
    @(negedge clk);
    chk1("spur_stay_idle", pmem_read | pmem_write, 1'b0);

    // Drive all counters into saturation and past it
    for (int k = 0; k < 4; k++)
      tie_run("sat", 32'h0000_3000 + ADDR_W'(k), 32'h0000_4000 + ADDR_W'(k), {32{8'hC3}}, {32{8'h3C}});
    chkc("sat_i_max", cnt_i_grants, CMAX);
    chkc("sat_d_max", cnt_d_grants, CMAX);
    chkc("sat_c_max", cnt_conflicts, CMAX);

    chk1("sb_drained", sb.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
